cla_add_pipe: RTL

Two-stage pipelined WIDTH-bit adder/subtractor for the stack CPU ALU. It sits directly upstream of the 4-block lookahead carry unit `LCU_4`: it forms the per-bit generate/propagate signals and feeds them to one `LCU_4` per nibble plus one second-level `LCU_4`. It then produces sum and flags. Operands arrive and results leave over valid/ready handshakes, so the block can stall behind a busy consumer, such as the stack write-back, without losing data.

---
 rtl/cla_add_pipe_pkg.sv | 30 +++
 rtl/LCU_4.sv | 18 +
 rtl/cla_pg_4.sv | 18 +
 rtl/cla_add_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cla_add_pipe_pkg.sv
// Shared ALU definitions: op encodings, flag bit positions and operand helpers
// for the pipelined lookahead adder.
package cla_add_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  localparam int MAX_NIB = 4;

  function automatic logic op_inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // SBC takes the flag as "no borrow", so ADC and SBC both pass it through.
  function automatic logic op_cin(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/LCU_4.sv
// 4-position lookahead carry unit: co[k] is the carry out of position k,
// expanded as a flat sum of products from the g/p inputs and cin.
module LCU_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] co
);

  always_comb begin
    co[0] = g[0] | (p[0] & cin);
    co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
  end

endmodule

// File: rtl/cla_pg_4.sv
// Nibble slice: group generate/propagate for the second-level LCU and the
// nibble sum from bit propagates and the carries into each bit.
module cla_pg_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic [3:0] c,
  output logic       gg,
  output logic       pg,
  output logic [3:0] sum
);

  always_comb begin
    gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg  = &p;
    sum = p ^ c;
  end

endmodule

// File: rtl/cla_add_pipe.sv
// Two-stage valid/ready adder/subtractor: stage 1 registers bit g/p, stage 2
// resolves carries through two LCU levels into a held output register.
module cla_add_pipe
  import cla_add_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags
);

  localparam int NIB = WIDTH / 4;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic             c0_q, c0_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic             stall, adv, accept;
  logic [WIDTH-1:0] b_eff, bit_c, sum_c;
  logic [MAX_NIB-1:0] grp_g, grp_p, top_co;
  logic [NIB-1:0]   nib_cin;
  logic [3:0]       flags_c;

  // in_ready depends combinationally on out_ready so a draining pipe accepts every cycle.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    adv      = s1_valid_q & ~stall;
    in_ready = ~s1_valid_q | ~stall;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    b_eff      = op_inv_b(in_op) ? ~in_b : in_b;
    g_d        = g_q;
    p_d        = p_q;
    c0_d       = c0_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    s1_valid_d = accept | (s1_valid_q & ~adv);
    if (accept) begin
      g_d     = in_a & b_eff;
      p_d     = in_a ^ b_eff;
      c0_d    = op_cin(in_op, in_cin);
      a_msb_d = in_a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
  end

  assign nib_cin[0] = c0_q;

  for (genvar i = 1; i < NIB; i++) begin : g_nib_cin
    assign nib_cin[i] = top_co[i-1];
  end

  // Bit-level LCU sees the nibble carry-in as a generate in slot 0 (p=0), so
  // its four carry outputs are exactly the carries into bits 0..3.
  for (genvar i = 0; i < NIB; i++) begin : g_nib
    LCU_4 u_lcu (
      .g   ({g_q[4*i +: 3], nib_cin[i]}),
      .p   ({p_q[4*i +: 3], 1'b0}),
      .cin (1'b0),
      .co  (bit_c[4*i +: 4])
    );
    cla_pg_4 u_pg (
      .g   (g_q[4*i +: 4]),
      .p   (p_q[4*i +: 4]),
      .c   (bit_c[4*i +: 4]),
      .gg  (grp_g[i]),
      .pg  (grp_p[i]),
      .sum (sum_c[4*i +: 4])
    );
  end

  for (genvar i = NIB; i < MAX_NIB; i++) begin : g_pad
    assign grp_g[i] = 1'b0;
    assign grp_p[i] = 1'b0;
  end

  LCU_4 u_lcu_top (
    .g   (grp_g),
    .p   (grp_p),
    .cin (c0_q),
    .co  (top_co)
  );

  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_C] = top_co[NIB-1];
    flags_c[FLAG_V] = (a_msb_q == b_msb_q) & (sum_c[WIDTH-1] != a_msb_q);
    flags_c[FLAG_Z] = ~|sum_c;
    flags_c[FLAG_N] = sum_c[WIDTH-1];
  end

  always_comb begin
    out_valid_d = adv | (out_valid_q & ~out_ready);
    out_sum_d   = adv ? sum_c   : out_sum_q;
    out_flags_d = adv ? flags_c : out_flags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      g_q         <= '0;
      p_q         <= '0;
      c0_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      g_q         <= g_d;
      p_q         <= p_d;
      c0_q        <= c0_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_flags = out_flags_q;

endmodule
